// File: rtl/serial_mmio_ctrl_pkg.sv
// Shared register map and STATUS bit positions for the serial MMIO controller.
package serial_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_RX_FULL  = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_OVF   = 3;
  localparam int ST_CNT_LSB  = 8;

endpackage

// File: rtl/serial_mmio_ctrl_if.sv
// CPU register bus and serial port pins of the controller, bundled as one interface.
// Serial handshake: a byte moves when the sender's wren/valid and the receiver's ready/rden are high at the same edge.
interface serial_mmio_ctrl_if;
  logic        cpu_addr;
  logic        cpu_wren;
  logic        cpu_rden;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic [7:0]  serial_in;
  logic        serial_valid_in;
  logic        serial_rden_out;
  logic [7:0]  serial_out;
  logic        serial_ready_in;
  logic        serial_wren_out;

  modport master (
    output cpu_addr, cpu_wren, cpu_rden, cpu_wdata,
    input  cpu_rdata,
    output serial_in, serial_valid_in, serial_ready_in,
    input  serial_rden_out, serial_out, serial_wren_out
  );

  modport slave (
    input  cpu_addr, cpu_wren, cpu_rden, cpu_wdata,
    output cpu_rdata,
    input  serial_in, serial_valid_in, serial_ready_in,
    output serial_rden_out, serial_out, serial_wren_out
  );
endinterface

// File: rtl/serial_mmio_ctrl_byte_fifo.sv
// Synchronous byte FIFO; push is judged against the pre-edge count, so a
// simultaneous pop never makes room for a push into a full FIFO.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [7:0]       data_i,
  input  logic             pop_i,
  output logic [7:0]       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/serial_mmio_ctrl.sv
// Serial MMIO controller: DATA/STATUS registers, TX FIFO drain and one-byte RX holding register.
// Defining SERIAL_LOOPBACK_EN routes drained TX bytes into the RX register instead of the port.
module serial_mmio_ctrl
  import serial_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int CNT_W    = $clog2(TX_DEPTH) + 1
) (
  input  logic clock,
  input  logic reset,
  serial_mmio_ctrl_if.slave bus
);
  logic             tx_push, tx_pop, tx_full, tx_empty, tx_to_port;
  logic [7:0]       tx_head;
  logic [CNT_W-1:0] tx_count;
  logic             rx_accept;
  logic [7:0]       rx_byte;
  logic             rd_data, wr_status;
  logic [31:0]      status_word;

  logic        rx_full_q, rx_full_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  sout_q, sout_d;
  logic        swren_q, swren_d;
  logic        unused_wdata;

  assign tx_push      = bus.cpu_wren && (bus.cpu_addr == REG_DATA);
  assign wr_status    = bus.cpu_wren && (bus.cpu_addr == REG_STATUS);
  assign rd_data      = bus.cpu_rden && (bus.cpu_addr == REG_DATA);
  assign unused_wdata = ^bus.cpu_wdata[31:8];

`ifdef SERIAL_LOOPBACK_EN
  logic unused_port;
  assign unused_port         = ^{bus.serial_in, bus.serial_valid_in, bus.serial_ready_in};
  assign tx_pop              = !tx_empty && !rx_full_q;
  assign tx_to_port          = 1'b0;
  assign rx_accept           = tx_pop;
  assign rx_byte             = tx_head;
  assign bus.serial_rden_out = 1'b0;
`else
  assign tx_pop              = !tx_empty && bus.serial_ready_in;
  assign tx_to_port          = tx_pop;
  assign rx_accept           = bus.serial_valid_in && !rx_full_q;
  assign rx_byte             = bus.serial_in;
  assign bus.serial_rden_out = rx_accept;
`endif

  byte_fifo #(.DEPTH(TX_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (tx_push),
    .data_i  (bus.cpu_wdata[7:0]),
    .pop_i   (tx_pop),
    .head_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  always_comb begin
    status_word                          = '0;
    status_word[ST_RX_FULL]              = rx_full_q;
    status_word[ST_TX_FULL]              = tx_full;
    status_word[ST_TX_EMPTY]             = tx_empty;
    status_word[ST_TX_OVF]               = tx_ovf_q;
    status_word[ST_CNT_LSB +: CNT_W]     = tx_count;
  end

  // rx_accept already requires !rx_full_q, so it never collides with the read clear.
  always_comb begin
    rx_full_d = rx_full_q;
    rx_data_d = rx_data_q;
    if (rd_data) rx_full_d = 1'b0;
    if (rx_accept) begin
      rx_data_d = rx_byte;
      rx_full_d = 1'b1;
    end

    tx_ovf_d = tx_ovf_q;
    if (wr_status && bus.cpu_wdata[ST_TX_OVF]) tx_ovf_d = 1'b0;
    if (tx_push && tx_full) tx_ovf_d = 1'b1;

    swren_d = 1'b0;
    sout_d  = sout_q;
    if (tx_to_port) begin
      swren_d = 1'b1;
      sout_d  = tx_head;
    end

    rdata_d = '0;
    if (bus.cpu_rden) begin
      if (bus.cpu_addr == REG_DATA) rdata_d = {24'b0, rx_data_q};
      else                          rdata_d = status_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_full_q <= 1'b0;
      rx_data_q <= '0;
      tx_ovf_q  <= 1'b0;
      rdata_q   <= '0;
      sout_q    <= '0;
      swren_q   <= 1'b0;
    end else begin
      rx_full_q <= rx_full_d;
      rx_data_q <= rx_data_d;
      tx_ovf_q  <= tx_ovf_d;
      rdata_q   <= rdata_d;
      sout_q    <= sout_d;
      swren_q   <= swren_d;
    end
  end

  assign bus.cpu_rdata       = rdata_q;
  assign bus.serial_out      = sout_q;
  assign bus.serial_wren_out = swren_q;
endmodule
